// File: rtl/reg_file_2r1w_pkg.sv
// Shared constants for the 32-entry register file and its bench.
// Includes sizes, the zero-register index and MIPS register names.
package reg_file_2r1w_pkg;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_AT   = 5'd1;
  localparam logic [ADDR_W-1:0] REG_V0   = 5'd2;
  localparam logic [ADDR_W-1:0] REG_V1   = 5'd3;
  localparam logic [ADDR_W-1:0] REG_A1   = 5'd5;
  localparam logic [ADDR_W-1:0] REG_T0   = 5'd8;
  localparam logic [ADDR_W-1:0] REG_T1   = 5'd9;
  localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [ADDR_W-1:0] REG_FP   = 5'd30;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;
endpackage

// File: rtl/reg_file_2r1w_if.sv
// Write port and two read ports of the register file.
// Reads are combinational; there is no backpressure on any port.
interface reg_file_2r1w_if
  import reg_file_2r1w_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [WIDTH-1:0]  wd;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [WIDTH-1:0]  rd1;
  logic [WIDTH-1:0]  rd2;

  modport master (output we, wa, wd, ra1, ra2, input rd1, rd2);
  modport slave  (input we, wa, wd, ra1, ra2, output rd1, rd2);
endinterface

// File: rtl/reg_file_2r1w_decoder_5to32.sv
// One-hot 5-to-32 address decode gated by an enable.
// Purely combinational; no backpressure.
module decoder_5to32
  import reg_file_2r1w_pkg::*;
(
  input  logic [ADDR_W-1:0]   addr,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end
endmodule

// File: rtl/reg_file_2r1w.sv
// 32-entry 2-read/1-write register file, r0 hardwired to zero.
// Reads zero-latency (optional same-cycle write bypass), writes land on the next edge; no backpressure.
module reg_file_2r1w
  import reg_file_2r1w_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BYPASS = 1
)(
  input  logic            clk,
  input  logic            reset,
  reg_file_2r1w_if.slave  rf
);
  localparam logic BYP_EN = (BYPASS != 0);

  logic [NUM_REGS-1:0] load;
  logic                unused_load0;
  logic [WIDTH-1:0]    regs [1:NUM_REGS-1];
  logic [WIDTH-1:0]    rd1_stored;
  logic [WIDTH-1:0]    rd2_stored;
  logic                wr_live;
  logic                byp1;
  logic                byp2;

  decoder_5to32 u_wdec (
    .addr   (rf.wa),
    .en     (rf.we & ~reset),
    .onehot (load)
  );

  // r0 has no storage, so its decode line goes nowhere.
  assign unused_load0 = load[0];

  always_ff @(posedge clk) begin
    for (int i = 1; i < NUM_REGS; i++) begin
      if (reset)        regs[i] <= '0;
      else if (load[i]) regs[i] <= rf.wd;
    end
  end

  // Per-bit 32:1 select per port, input 0 tied low for r0.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [NUM_REGS-1:0] col;
    assign col[0] = 1'b0;
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
      assign col[i] = regs[i][b];
    end
    assign rd1_stored[b] = col[rf.ra1];
    assign rd2_stored[b] = col[rf.ra2];
  end

  // wa != 0 in wr_live keeps a bypass from ever hitting a read of r0.
  assign wr_live = rf.we & ~reset & (rf.wa != REG_ZERO);
  assign byp1    = BYP_EN & wr_live & (rf.wa == rf.ra1);
  assign byp2    = BYP_EN & wr_live & (rf.wa == rf.ra2);

  assign rf.rd1 = byp1 ? rf.wd : rd1_stored;
  assign rf.rd2 = byp2 ? rf.wd : rd2_stored;
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench: one bypassing and one non-bypassing instance driven in lockstep.
// Expected read data is queued at drive time and compared before the next edge.
module tb_reg_file_2r1w;
  import reg_file_2r1w_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reg_file_2r1w_if #(.WIDTH(32)) bus_b ();
  reg_file_2r1w_if #(.WIDTH(32)) bus_n ();

  reg_file_2r1w #(.WIDTH(32), .BYPASS(1)) u_dut_b (.clk(clk), .reset(reset), .rf(bus_b.slave));
  reg_file_2r1w #(.WIDTH(32), .BYPASS(0)) u_dut_n (.clk(clk), .reset(reset), .rf(bus_n.slave));

  typedef struct {
    string       tag;
    logic [31:0] b1;
    logic [31:0] b2;
    logic [31:0] n1;
    logic [31:0] n2;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] mdl [NUM_REGS];
  int          n_cmp = 0;
  int          n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp, input logic r,
                                         input logic w, input logic [4:0] a, input logic [31:0] d);
    if (ra == 5'd0) return 32'h0;
    if (byp && !r && w && a == ra) return d;
    return mdl[ra];
  endfunction

  task automatic step(input string tag, input logic r, input logic w, input logic [4:0] a,
                      input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    @(negedge clk);
    reset = r;
    bus_b.we = w; bus_b.wa = a; bus_b.wd = d; bus_b.ra1 = a1; bus_b.ra2 = a2;
    bus_n.we = w; bus_n.wa = a; bus_n.wd = d; bus_n.ra1 = a1; bus_n.ra2 = a2;
    e.tag = tag;
    e.b1  = exp_rd(a1, 1'b1, r, w, a, d);
    e.b2  = exp_rd(a2, 1'b1, r, w, a, d);
    e.n1  = exp_rd(a1, 1'b0, r, w, a, d);
    e.n2  = exp_rd(a2, 1'b0, r, w, a, d);
    exp_q.push_back(e);
    #1;
    e = exp_q.pop_front();
    chk({e.tag, "/byp_rd1"}, bus_b.rd1, e.b1);
    chk({e.tag, "/byp_rd2"}, bus_b.rd2, e.b2);
    chk({e.tag, "/nob_rd1"}, bus_n.rd1, e.n1);
    chk({e.tag, "/nob_rd2"}, bus_n.rd2, e.n2);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < NUM_REGS; i++) mdl[i] = 32'h0;
    end else if (w && a != 5'd0) begin
      mdl[a] = d;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] a1, a2, wa;
    logic       w;

    // First reset: only r0 is defined before it, so read r0 on both ports.
    step("rst0", 1'b1, 1'b0, 5'd0, 32'h0, REG_ZERO, REG_ZERO);

    // Reset clears a written register; during the reset cycle stored data still shows.
    step("wr_r5", 1'b0, 1'b1, REG_A1, 32'hDEADBEEF, REG_A1, REG_ZERO);
    step("rst_r5", 1'b1, 1'b0, 5'd0, 32'h0, REG_A1, REG_A1);
    step("post_rst_r5", 1'b0, 1'b0, 5'd0, 32'h0, REG_A1, REG_A1);
    for (int i = 0; i < NUM_REGS; i++)
      step($sformatf("sweep%0d", i), 1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));

    // Basic write/read, then r31 with r8 unchanged.
    step("wr_t0", 1'b0, 1'b1, REG_T0, 32'h12345678, REG_T0, REG_T0);
    step("rd_t0", 1'b0, 1'b0, 5'd0, 32'h0, REG_T0, REG_T0);
    step("wr_ra", 1'b0, 1'b1, REG_RA, 32'hA5A5A5A5, REG_T0, REG_RA);
    step("rd_ra", 1'b0, 1'b0, 5'd0, 32'h0, REG_T0, REG_RA);

    // r0 cannot be written, not even via bypass.
    step("wr_r0", 1'b0, 1'b1, REG_ZERO, 32'hFFFFFFFF, REG_ZERO, REG_ZERO);
    step("rd_r0", 1'b0, 1'b0, 5'd0, 32'h0, REG_ZERO, REG_T0);
    step("rd_r0_ra", 1'b0, 1'b0, 5'd0, 32'h0, REG_RA, REG_ZERO);

    // Same-cycle bypass on both ports vs stored value without bypass.
    step("wr_t1a", 1'b0, 1'b1, REG_T1, 32'h11111111, REG_ZERO, REG_ZERO);
    step("byp_t1", 1'b0, 1'b1, REG_T1, 32'h22222222, REG_T1, REG_T1);
    step("rd_t1", 1'b0, 1'b0, 5'd0, 32'h0, REG_T1, REG_T1);
    step("we0_t1", 1'b0, 1'b0, REG_T1, 32'h33333333, REG_T1, REG_T1);
    step("rd_t1b", 1'b0, 1'b0, 5'd0, 32'h0, REG_T1, REG_T1);

    // Reset wins over a colliding write and suppresses bypass.
    step("wr_v1", 1'b0, 1'b1, REG_V1, 32'h0000CAFE, REG_ZERO, REG_ZERO);
    step("rst_wr_v1", 1'b1, 1'b1, REG_V1, 32'hBEEF0000, REG_V1, REG_V1);
    step("post_v1", 1'b0, 1'b0, 5'd0, 32'h0, REG_V1, REG_T0);

    // Load index pattern, then random dual-port reads with occasional writes.
    for (int i = 1; i < NUM_REGS; i++)
      step($sformatf("load%0d", i), 1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101, 5'(i), 5'(i - 1));
    for (int i = 0; i < 1000; i++) begin
      a1 = 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      w  = ($urandom_range(0, 7) == 0);
      wa = ($urandom_range(0, 1) == 0) ? a1 : 5'($urandom_range(0, 31));
      step($sformatf("rnd%0d", i), 1'b0, w, wa, $urandom, a1, a2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
